fifo_word_serializer: RTL

Drain-side companion to the team's synchronous FIFO queue. Pops words from the FIFO read port (`deq` / `deq_data` / `empty`) and transmits each as an asynchronous serial frame: start bit, `WIDTH` data bits LSB first, stop bit. Sits between a FIFO instance and an off-block serial line and owns all FIFO read timing.

---
 rtl/fifo_word_serializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_word_serializer.sv
// Drains a synchronous FIFO and sends each word as an async serial frame:
// start bit, WIDTH data bits LSB first, stop bit. Owns all FIFO read timing.
module fifo_word_serializer #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_deq,
    input  logic [WIDTH-1:0] fifo_deq_data,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WIDTH-1:0]  shreg;
    logic              bit_end;
    logic              pop_ok;

    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
        pop_ok  = enable && !fifo_empty;
    end

    // Outputs are registered, so each is assigned alongside the transition
    // into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            fifo_deq  <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            fifo_deq  <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_ok) begin
                        state    <= POP;
                        fifo_deq <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg    <= fifo_deq_data;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop_ok) begin
                            state    <= POP;
                            fifo_deq <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // word_done is registered, so raise it one cycle early
                        if (baud_cnt == BAUD_PRE)
                            word_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
